demux_scan_ctrl: RTL and testbench

Upstream driver for the 1-to-8 gate-level demultiplexer.
- Steps the demux select lines s2..s0 through channels 0..7, holding each channel for a programmable dwell time.
- Drives the demux data input from a latched 8-bit pattern, one bit per channel.
- Supports single-pass and continuous scanning, abort, and start/busy/done handshaking toward the controlling logic.

---
 rtl/demux_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_demux_scan_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : demux_scan_ctrl
// Brief    : Steps a 1-to-8 demux through channels 0..7 with a programmable
//            dwell, driving each channel's data bit from a latched pattern.
// Revision : 1.0
// ============================================================================
module demux_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [7:0]         pattern,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               s2,
  output logic               s1,
  output logic               s0,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] c_cnt_one = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [2:0]         r_sel;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_last;
  logic [7:0]         r_pat;
  logic               r_a;
  logic               r_busy;
  logic               r_done;

  logic [DWELL_W-1:0] w_dwell_last;
  logic [2:0]         w_next_sel;

  // Terminal count is D-1 with D = max(dwell,1); storing D-1 keeps the
  // all-ones dwell value representable in DWELL_W bits.
  assign w_dwell_last = (dwell == '0) ? '0 : (dwell - c_cnt_one);
  assign w_next_sel   = r_sel + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_pat   <= '0;
      r_a     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_a    <= 1'b0;
          r_sel  <= '0;
          r_cnt  <= '0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (start && !abort) begin
            r_pat   <= pattern;
            r_last  <= w_dwell_last;
            r_a     <= pattern[0];
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_a     <= 1'b0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == r_last) begin
            r_cnt <= '0;
            if (r_sel == 3'd7) begin
              if (continuous) begin
                // Wrap: refresh the pattern but keep the dwell latched at start.
                r_sel <= '0;
                r_pat <= pattern;
                r_a   <= pattern[0];
              end else begin
                r_state <= ST_DONE;
                r_a     <= 1'b0;
                r_sel   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_sel <= w_next_sel;
              r_a   <= r_pat[w_next_sel];
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_a     <= 1'b0;
          r_sel   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign a    = r_a;
  assign s2   = r_sel[2];
  assign s1   = r_sel[1];
  assign s0   = r_sel[0];
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_demux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_scan_ctrl
// Brief    : Self-checking bench for demux_scan_ctrl against a timing model.
// Revision : 1.0
// ============================================================================
module tb_demux_scan_ctrl;

  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic               continuous;
  logic [7:0]         pattern;
  logic [DWELL_W-1:0] dwell;
  logic               a, s2, s1, s0, busy, done;

  int n_tests;
  int n_fail;

  // Reference: 0 = idle, 1 = scanning, 2 = done; t counts cycles into a pass.
  int         m_mode;
  int         m_t;
  int         m_d;
  logic [7:0] m_pat;

  demux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .pattern    (pattern),
    .dwell      (dwell),
    .a          (a),
    .s2         (s2),
    .s1         (s1),
    .s0         (s0),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_ch();
    return (m_mode == 1) ? (m_t / m_d) : 0;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (start && !abort) begin
        m_mode = 1;
        m_t    = 0;
        m_d    = (dwell == 0) ? 1 : int'(dwell);
        m_pat  = pattern;
      end
    end else if (m_mode == 1) begin
      if (abort) begin
        m_mode = 0;
      end else begin
        m_t++;
        if (m_t == 8 * m_d) begin
          if (continuous) begin
            m_t   = 0;
            m_pat = pattern;
          end else begin
            m_mode = 2;
          end
        end
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic compare_all();
    int ch;
    ch = model_ch();
    check("a",    a,            (m_mode == 1) ? int'(m_pat[ch]) : 0);
    check("sel",  {s2, s1, s0}, ch);
    check("busy", busy,         (m_mode == 1) ? 1 : 0);
    check("done", done,         (m_mode == 2) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < n; i++) begin
      step();
      busy_n += int'(busy);
      done_n += int'(done);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int bn, dn, gap, guard;
    bit seen;
    n_tests = 0; n_fail = 0;
    m_mode = 0; m_t = 0; m_d = 1; m_pat = '0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    pattern = '0; dwell = '0;

    // Reset state, with start requested while held in reset.
    start = 1'b1;
    run(3, bn, dn);
    start = 1'b0;
    rst_n = 1'b1;
    run(2, bn, dn);

    // Single pass, dwell 2.
    pattern = 8'b1010_0110; dwell = 8'd2;
    pulse_start();
    run(20, bn, dn);
    check("pass_busy_len", bn + 1, 16);
    check("pass_done_cnt", dn, 1);

    // Dwell 0 behaves as 1.
    pattern = 8'hFF; dwell = 8'd0;
    pulse_start();
    run(12, bn, dn);
    check("dwell0_busy_len", bn + 1, 8);
    check("dwell0_done_cnt", dn, 1);

    // Continuous, pattern swapped during the first pass, then stop.
    pattern = 8'h0F; dwell = 8'd1; continuous = 1'b1;
    pulse_start();
    run(2, bn, dn);
    pattern = 8'hF0;
    run(8, bn, dn);
    continuous = 1'b0;
    run(10, bn, dn);
    check("cont_done_cnt", dn, 1);

    // Abort during channel 5.
    pattern = 8'hFF; dwell = 8'd3;
    pulse_start();
    guard = 0;
    while (model_ch() != 5 && guard < 100) begin step(); guard++; end
    check("abort_reach_ch5", model_ch(), 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    run(30, bn, dn);
    check("abort_no_done", dn, 0);
    check("abort_no_busy", bn, 0);

    // start with abort in IDLE.
    start = 1'b1; abort = 1'b1;
    run(3, bn, dn);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", bn, 0);

    // Async reset mid-scan at channel 3.
    pattern = 8'hFF; dwell = 8'd2;
    pulse_start();
    guard = 0;
    while (model_ch() != 3 && guard < 100) begin step(); guard++; end
    #2 rst_n = 1'b0;
    #1;
    check("rst_a",    a, 0);
    check("rst_sel",  {s2, s1, s0}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    m_mode = 0;
    run(2, bn, dn);
    rst_n = 1'b1;
    run(3, bn, dn);

    // start held through a pass: a gap of the DONE cycle plus one IDLE cycle.
    pattern = 8'h5A; dwell = 8'd1; start = 1'b1;
    seen = 0; guard = 0;
    while (!seen && guard < 200) begin step(); seen = done; guard++; end
    check("hold_done_seen", seen, 1);
    gap = 0; guard = 0;
    while (!busy && guard < 20) begin gap++; step(); guard++; end
    check("hold_busy_gap", gap, 2);
    start = 1'b0;
    run(12, bn, dn);

    // Maximum dwell.
    pattern = 8'h3C; dwell = 8'hFF;
    pulse_start();
    run(2050, bn, dn);
    check("dmax_busy_len", bn + 1, 2040);
    check("dmax_done_cnt", dn, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 59) == 0);
      pattern = 8'($urandom);
      if ($urandom_range(0, 15) == 0) continuous = ~continuous;
      dwell   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      step();
    end
    start = 1'b0; abort = 1'b1;
    run(3, bn, dn);
    abort = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
